// File: rtl/cubic_interp_engine.sv
// cubic_interp_engine
// Collects groups of four pixel samples P(-1), P(0), P(1), P(2) over a
// valid/ready input stream, then evaluates either a Catmull-Rom cubic or a
// linear interpolation at fraction x = frac / 2^FW. The result is rounded
// half-up (floor(v + 0.5)) and saturated to [0, 2^PW-1].
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid and ready are both 1. A producer holds its data stable while valid=1
// and ready=0; ready never depends combinationally on valid.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     input sample valid
//   in_ready     engine accepts a sample this cycle (registered)
//   in_pix       sample value, unsigned PW bits
//   in_frac      fraction, unsigned Q0.FW, captured with P(-1) only
//   mode         0 = Catmull-Rom cubic, 1 = linear, captured with P(-1) only
//   out_valid    result available (registered)
//   out_ready    consumer accepts result
//   out_pix      rounded, saturated result (registered)
//   o_dbg_state  current FSM state (0 = LOAD, 1 = CALC, 2 = OUT)
module cubic_interp_engine #(
  parameter int PW = 8,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pix,
  input  logic [FW-1:0] in_frac,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pix,
  output logic [1:0]    o_dbg_state
);

  // The whole polynomial is scaled by 2^(3*FW+1) so every term is an exact
  // integer: the 1/2 factor plus x^3 = f^3 / 2^(3*FW). NW leaves headroom
  // for the largest coefficient (|B| <= 6*(2^PW-1)) times f^2 shifted by FW.
  localparam int NW = PW + 3*FW + 6;
  localparam int SH = 3*FW + 1;

  localparam logic signed [NW-1:0] HALF = {{(NW-1){1'b0}}, 1'b1} << (SH-1);
  localparam logic signed [NW-1:0] MAXV = {{(NW-PW){1'b0}}, {PW{1'b1}}};

  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [PW-1:0] r_pm1, r_p0, r_p1, r_p2;
  logic [FW-1:0] r_frac;
  logic          r_mode;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [PW-1:0] r_out_pix;

  logic signed [NW-1:0] w_pm1, w_p0, w_p1, w_p2, w_f, w_f2, w_f3;
  logic signed [NW-1:0] w_a, w_b, w_c;
  logic signed [NW-1:0] w_cubic, w_lin, w_num, w_rnd;
  logic [PW-1:0]        w_sat;

  assign w_pm1 = {{(NW-PW){1'b0}}, r_pm1};
  assign w_p0  = {{(NW-PW){1'b0}}, r_p0};
  assign w_p1  = {{(NW-PW){1'b0}}, r_p1};
  assign w_p2  = {{(NW-PW){1'b0}}, r_p2};
  assign w_f   = {{(NW-FW){1'b0}}, r_frac};
  assign w_f2  = w_f * w_f;
  assign w_f3  = w_f2 * w_f;

  // A = P1 - Pm1, B = 2Pm1 - 5P0 + 4P1 - P2, C = -Pm1 + 3P0 - 3P1 + P2
  assign w_a = w_p1 - w_pm1;
  assign w_b = (w_pm1 <<< 1) - ((w_p0 <<< 2) + w_p0) + (w_p1 <<< 2) - w_p2;
  assign w_c = ((w_p0 <<< 1) + w_p0) - ((w_p1 <<< 1) + w_p1) + w_p2 - w_pm1;

  assign w_cubic = (w_p0 <<< SH) + ((w_f * w_a) <<< (2*FW))
                 + ((w_f2 * w_b) <<< FW) + (w_f3 * w_c);
  assign w_lin   = (w_p0 <<< SH) + ((w_f * (w_p1 - w_p0)) <<< (2*FW+1));
  assign w_num   = r_mode ? w_lin : w_cubic;

  // Arithmetic shift gives floor semantics for negative intermediates.
  assign w_rnd = (w_num + HALF) >>> SH;

  always_comb begin
    w_sat = w_rnd[PW-1:0];
    if (w_rnd < 0)         w_sat = '0;
    else if (w_rnd > MAXV) w_sat = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_idx       <= 2'd0;
      r_pm1       <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_frac      <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (in_valid && r_in_ready) begin
            unique case (r_idx)
              2'd0: begin
                r_pm1  <= in_pix;
                r_frac <= in_frac;
                r_mode <= mode;
              end
              2'd1: r_p0 <= in_pix;
              2'd2: r_p1 <= in_pix;
              2'd3: r_p2 <= in_pix;
              default: ;
            endcase
            if (r_idx == 2'd3) begin
              r_idx      <= 2'd0;
              r_in_ready <= 1'b0;
              r_state    <= CALC;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        CALC: begin
          r_out_pix   <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= LOAD;
          end
        end
        default: begin
          r_state     <= LOAD;
          r_idx       <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pix     = r_out_pix;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cubic_interp_engine.sv
module tb_cubic_interp_engine;
  localparam int PW = 8;
  localparam int FW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pix;
  logic [FW-1:0] in_frac;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pix;
  logic [1:0]    dbg_state;

  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  cubic_interp_engine #(.PW(PW), .FW(FW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_frac(in_frac), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // scoreboard monitor: pops on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_unexpected: got %0d expected no result (t=%0t)", out_pix, $time);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (out_pix !== e) begin
          n_errors++;
          $display("FAIL out_pix: got %0d expected %0d (t=%0t)", out_pix, e, $time);
        end
      end
    end
  end

  // driver: one 4-sample group with random idle gaps, garbage frac/mode after
  // P(-1), and in_valid held high with junk while the engine is busy.
  // Entered and left at #1 after a rising edge.
  task automatic send_group(input int pm1, input int p0, input int p1, input int p2,
                            input int frac, input int m, input int exp_v);
    int pix[4];
    int gaps;
    int waited;
    bit acc;
    pix = '{pm1, p0, p1, p2};
    exp_q.push_back(PW'(exp_v));
    for (int k = 0; k < 4; k++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_pix   = PW'($urandom_range(0, 255));
        in_frac  = FW'($urandom_range(0, 255));
        mode     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pix   = PW'(pix[k]);
      if (k == 0) begin
        in_frac = FW'(frac);
        mode    = 1'(m);
      end else begin
        in_frac = FW'($urandom_range(0, 255));
        mode    = 1'($urandom_range(0, 1));
      end
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        waited++;
        if (!acc && waited > 50) begin
          check("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    // CALC cycle: junk on the input must be ignored
    in_valid = 1'b1;
    in_pix   = PW'($urandom_range(0, 255));
    @(negedge clk);
    check("calc_out_valid", int'(out_valid), 0);
    check("calc_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_pix = PW'($urandom_range(0, 255));
    @(negedge clk);
    check("latency_out_valid", int'(out_valid), 1);
    check("out_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pix = '0; in_frac = '0; mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pix", int'(out_pix), 0);
    check("rst_state", int'(dbg_state), 0);
    @(posedge clk); #1;

    // directed vectors: pm1, p0, p1, p2, frac, mode, expected
    send_group( 10,  20,  30,  40, 128, 0,  25);
    send_group(  0, 255, 255,   0, 128, 0, 255);
    send_group(255,   0,   0, 255, 128, 0,   0);
    send_group(  7, 100, 200,   9,  64, 1, 125);
    send_group(  3,  77, 200,  11,   0, 0,  77);
    send_group(  3,  77, 200,  11,   0, 1,  77);
    send_group(  5,   0,   1,   5, 128, 1,   1);
    send_group(  5,   0,   1,   5, 127, 1,   0);
    send_group(  0,  10,   9,   0, 128, 1,  10);
    send_group(100, 100, 100,   0, 128, 0, 106);
    send_group(  0,   0, 255,   0, 255, 1, 254);
    send_group( 10,  20,  30,  40,  64, 0,  23);
    send_group(  0, 100,  50, 200, 128, 0,  72);

    // output back-pressure: result held for 5 cycles
    out_ready = 1'b0;
    send_group(10, 20, 30, 40, 128, 0, 25);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_pix", int'(out_pix), 25);
      check("stall_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready_same", int'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("release_in_ready_next", int'(in_ready), 1);
    check("release_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // reset after two accepted samples
    in_valid = 1'b1; in_pix = 8'd99; in_frac = 8'd200; mode = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_pix", int'(out_pix), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    send_group(10, 20, 30, 40, 64, 0, 23);

    // reset while a result is pending in OUT
    out_ready = 1'b0;
    send_group(100, 100, 100, 0, 128, 0, 106);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("outrst_out_valid", int'(out_valid), 0);
    check("outrst_out_pix", int'(out_pix), 0);
    check("outrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_group(0, 255, 255, 0, 128, 0, 255);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
